// File: rtl/bnn_seq_ctrl_if.sv
// bnn_seq_ctrl_if: stream, buffer-write and control bundle between the BNN sequencer and its datapath
interface bnn_seq_ctrl_if #(
    parameter int IMG_PIXELS = 784,
    parameter int NUM_KERNEL = 6,
    parameter int KW_BITS    = 25,
    parameter int FC_W_BITS  = 8640
);
    localparam int IMG_AW = IMG_PIXELS > 1 ? $clog2(IMG_PIXELS) : 1;
    localparam int W_AW   = NUM_KERNEL * KW_BITS > 1 ? $clog2(NUM_KERNEL * KW_BITS) : 1;
    localparam int FC_AW  = FC_W_BITS > 1 ? $clog2(FC_W_BITS) : 1;
    logic              start_cnn;
    logic              image_tvalid;
    logic [7:0]        image_tdata;
    logic              image_tready;
    logic              weight_tvalid;
    logic              weight_tdata;
    logic              weight_tready;
    logic              weightfc_tvalid;
    logic              weightfc_tdata;
    logic              weightfc_tready;
    logic              img_we;
    logic [IMG_AW-1:0] img_addr;
    logic [7:0]        img_wdata;
    logic              w_we;
    logic [W_AW-1:0]   w_addr;
    logic              w_wdata;
    logic              wfc_we;
    logic [FC_AW-1:0]  wfc_addr;
    logic              wfc_wdata;
    logic              start_window;
    logic              start_conv;
    logic              conv_done;
    logic              fc_start;
    logic              fc_done;
    logic [3:0]        conv_cnt;
    logic              busy;
    logic              cnn_done;
    modport master (
        input  start_cnn, image_tvalid, image_tdata, weight_tvalid, weight_tdata,
               weightfc_tvalid, weightfc_tdata, conv_done, fc_done,
        output image_tready, weight_tready, weightfc_tready, img_we, img_addr, img_wdata,
               w_we, w_addr, w_wdata, wfc_we, wfc_addr, wfc_wdata,
               start_window, start_conv, fc_start, conv_cnt, busy, cnn_done
    );
    modport slave (
        output start_cnn, image_tvalid, image_tdata, weight_tvalid, weight_tdata,
               weightfc_tvalid, weightfc_tdata, conv_done, fc_done,
        input  image_tready, weight_tready, weightfc_tready, img_we, img_addr, img_wdata,
               w_we, w_addr, w_wdata, wfc_we, wfc_addr, wfc_wdata,
               start_window, start_conv, fc_start, conv_cnt, busy, cnn_done
    );
endinterface

// File: rtl/bnn_seq_ctrl.sv
// bnn_seq_ctrl: loads image/conv/FC buffers, runs each conv kernel, then FC, then signals completion
module bnn_seq_ctrl #(
    parameter int IMG_PIXELS = 784,
    parameter int NUM_KERNEL = 6,
    parameter int KW_BITS    = 25,
    parameter int FC_W_BITS  = 8640
) (
    input logic             clk,
    input logic             rstn,
    bnn_seq_ctrl_if.master  bus
);
    localparam int W_N    = NUM_KERNEL * KW_BITS;
    localparam int IMG_AW = IMG_PIXELS > 1 ? $clog2(IMG_PIXELS) : 1;
    localparam int W_AW   = W_N > 1 ? $clog2(W_N) : 1;
    localparam int FC_AW  = FC_W_BITS > 1 ? $clog2(FC_W_BITS) : 1;
    localparam int CW     = IMG_AW > W_AW ? (IMG_AW > FC_AW ? IMG_AW : FC_AW)
                                          : (W_AW > FC_AW ? W_AW : FC_AW);

    typedef enum logic [3:0] {
        IDLE, LOAD_IMG, LOAD_W, CONV_START, CONV_WAIT, LOAD_FC, FC_START, FC_WAIT, DONE
    } state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     cnt;
    logic [3:0]        conv_cnt;
    logic              img_we, w_we, wfc_we;
    logic [IMG_AW-1:0] img_addr;
    logic [W_AW-1:0]   w_addr;
    logic [FC_AW-1:0]  wfc_addr;
    logic [7:0]        img_wdata;
    logic              w_wdata, wfc_wdata;

    wire acc_img  = bus.image_tvalid & (state == LOAD_IMG);
    wire acc_w    = bus.weight_tvalid & (state == LOAD_W);
    wire acc_fc   = bus.weightfc_tvalid & (state == LOAD_FC);
    wire last_img = acc_img && cnt == CW'(IMG_PIXELS - 1);
    wire last_w   = acc_w && cnt == CW'(W_N - 1);
    wire last_fc  = acc_fc && cnt == CW'(FC_W_BITS - 1);
    wire start_ok = state == IDLE && bus.start_cnn;

    // state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    // next-state decode
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:       state_nx = bus.start_cnn ? LOAD_IMG : IDLE;
            LOAD_IMG:   state_nx = last_img ? LOAD_W : LOAD_IMG;
            LOAD_W:     state_nx = last_w ? CONV_START : LOAD_W;
            CONV_START: state_nx = CONV_WAIT;
            CONV_WAIT:  state_nx = !bus.conv_done ? CONV_WAIT
                                 : conv_cnt == 4'(NUM_KERNEL - 1) ? LOAD_FC : CONV_START;
            LOAD_FC:    state_nx = last_fc ? FC_START : LOAD_FC;
            FC_START:   state_nx = FC_WAIT;
            FC_WAIT:    state_nx = bus.fc_done ? DONE : FC_WAIT;
            DONE:       state_nx = IDLE;
            default:    state_nx = IDLE;
        endcase
    end

    // beat counter and kernel index; the last beat of each load clears the beat counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt      <= '0;
            conv_cnt <= '0;
        end else begin
            cnt      <= (start_ok || last_img || last_w || last_fc) ? '0
                      : (acc_img || acc_w || acc_fc) ? cnt + 1'b1 : cnt;
            conv_cnt <= start_ok ? 4'd0
                      : (state == CONV_WAIT && bus.conv_done) ? conv_cnt + 4'd1 : conv_cnt;
        end
    end

    // buffer writes land one cycle after the accepted beat, addressed by its beat index
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            img_we    <= 1'b0;
            w_we      <= 1'b0;
            wfc_we    <= 1'b0;
            img_addr  <= '0;
            w_addr    <= '0;
            wfc_addr  <= '0;
            img_wdata <= '0;
            w_wdata   <= 1'b0;
            wfc_wdata <= 1'b0;
        end else begin
            img_we    <= acc_img;
            w_we      <= acc_w;
            wfc_we    <= acc_fc;
            img_addr  <= acc_img ? cnt[IMG_AW-1:0] : img_addr;
            w_addr    <= acc_w ? cnt[W_AW-1:0] : w_addr;
            wfc_addr  <= acc_fc ? cnt[FC_AW-1:0] : wfc_addr;
            img_wdata <= acc_img ? bus.image_tdata : img_wdata;
            w_wdata   <= acc_w ? bus.weight_tdata : w_wdata;
            wfc_wdata <= acc_fc ? bus.weightfc_tdata : wfc_wdata;
        end
    end

    assign bus.image_tready    = state == LOAD_IMG;
    assign bus.weight_tready   = state == LOAD_W;
    assign bus.weightfc_tready = state == LOAD_FC;
    assign bus.start_window    = state == CONV_START;
    assign bus.start_conv      = state == CONV_START;
    assign bus.fc_start        = state == FC_START;
    assign bus.cnn_done        = state == DONE;
    assign bus.busy            = state != IDLE;
    assign bus.conv_cnt        = conv_cnt;
    assign bus.img_we          = img_we;
    assign bus.img_addr        = img_addr;
    assign bus.img_wdata       = img_wdata;
    assign bus.w_we            = w_we;
    assign bus.w_addr          = w_addr;
    assign bus.w_wdata         = w_wdata;
    assign bus.wfc_we          = wfc_we;
    assign bus.wfc_addr        = wfc_addr;
    assign bus.wfc_wdata       = wfc_wdata;
endmodule

// File: tb/tb_bnn_seq_ctrl.sv
// tb_bnn_seq_ctrl: randomized runs of the BNN sequencer against a queue-based scoreboard
module tb_bnn_seq_ctrl;
    localparam int IMG = 4, NK = 2, KW = 3, FCB = 5, WN = NK * KW;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    int   tests = 0, fails = 0;
    int   q_img[$], q_w[$], q_fc[$], q_conv[$], q_fcs[$], q_done[$];
    logic pa_img = 1'b0, pa_w = 1'b0, pa_fc = 1'b0;

    always #5 clk = ~clk;

    bnn_seq_ctrl_if #(.IMG_PIXELS(IMG), .NUM_KERNEL(NK), .KW_BITS(KW), .FC_W_BITS(FCB)) bus ();
    bnn_seq_ctrl #(.IMG_PIXELS(IMG), .NUM_KERNEL(NK), .KW_BITS(KW), .FC_W_BITS(FCB)) dut (
        .clk(clk), .rstn(rstn), .bus(bus)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_zero(input string name);
        logic [63:0] v;
        v = 64'({bus.image_tready, bus.weight_tready, bus.weightfc_tready, bus.img_we, bus.img_addr,
                 bus.img_wdata, bus.w_we, bus.w_addr, bus.w_wdata, bus.wfc_we, bus.wfc_addr,
                 bus.wfc_wdata, bus.start_window, bus.start_conv, bus.fc_start, bus.conv_cnt,
                 bus.busy, bus.cnn_done});
        chk(name, longint'(v), 0);
    endtask

    task automatic idle_inputs();
        bus.start_cnn = 0; bus.image_tvalid = 0; bus.image_tdata = 0;
        bus.weight_tvalid = 0; bus.weight_tdata = 0; bus.weightfc_tvalid = 0;
        bus.weightfc_tdata = 0; bus.conv_done = 0; bus.fc_done = 0;
    endtask

    task automatic set_stream(input int kind, input bit v, input int d);
        bus.image_tvalid    = kind == 0 && v;
        bus.image_tdata     = 8'(d);
        bus.weight_tvalid   = kind == 1 && v;
        bus.weight_tdata    = d[0];
        bus.weightfc_tvalid = kind == 2 && v;
        bus.weightfc_tdata  = d[0];
    endtask

    function automatic bit tready(input int kind);
        return kind == 0 ? bus.image_tready : kind == 1 ? bus.weight_tready : bus.weightfc_tready;
    endfunction

    // Offers beats of one stream until n are accepted, then keeps valid high for extra cycles
    task automatic drive(input int kind, input int mode, input int extra, input bit spur);
        int n = kind == 0 ? IMG : kind == 1 ? WN : FCB;
        int k = 0, cyc = 0, d;
        bit v, sp_done = 0, chk_next = 0;
        while (k < n && cyc < 200) begin
            @(posedge clk); #1;
            v = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
            d = kind != 0 ? int'($urandom_range(0, 1)) : mode == 0 ? (k + 1) * 17 : int'($urandom_range(0, 255));
            set_stream(kind, v, d);
            bus.conv_done = spur && k == 2 && !sp_done;
            @(negedge clk);
            if (chk_next) begin
                chk("spur_conv_wready", bus.weight_tready, 1);
                chk("spur_conv_cnt", bus.conv_cnt, 0);
                chk("spur_conv_no_window", bus.start_window, 0);
                chk_next = 0;
            end
            if (bus.conv_done) begin sp_done = 1; chk_next = 1; end
            if (v && tready(kind)) begin
                if (kind == 0) q_img.push_back(k * 256 + d);
                else if (kind == 1) q_w.push_back(k * 2 + d);
                else q_fc.push_back(k * 2 + d);
                k++;
            end
            cyc++;
        end
        if (k < n) chk("load_timeout", k, n);
        for (int i = 0; i <= extra; i++) begin
            @(posedge clk); #1;
            set_stream(kind, i < extra, 0);
            bus.conv_done = 0;
            @(negedge clk);
            chk("tready_after_last", tready(kind), 0);
            if (i == 0 && kind == 1) chk("start_conv_after_w", bus.start_conv, 1);
            if (i == 0 && kind == 2) chk("fc_start_after_fc", bus.fc_start, 1);
        end
        set_stream(kind, 0, 0);
    endtask

    task automatic wait_window();
        int t = 0;
        do @(negedge clk); while (!bus.start_window && ++t < 50);
        chk("start_window_seen", bus.start_window, 1);
    endtask

    task automatic run(input int mi, input int mw, input int mf, input int ei, input int ew,
                       input bit spur, input int abort_k, input bit hold);
        int t;
        for (int k = 0; k < NK; k++) q_conv.push_back(k);
        q_fcs.push_back(1);
        q_done.push_back(1);
        @(posedge clk); #1;
        bus.start_cnn = 1;
        @(posedge clk); #1;
        if (!hold) bus.start_cnn = 0;
        @(negedge clk);
        chk("run_busy", bus.busy, 1);
        chk("run_cnt0", bus.conv_cnt, 0);
        drive(0, mi, ei, 0);
        drive(1, mw, ew, spur);
        for (int kk = 0; kk < NK; kk++) begin
            if (kk > 0) wait_window();
            if (abort_k == kk) begin
                @(posedge clk); #3;
                rstn = 0;
                #1;
                check_zero("abort_zero");
                q_conv.delete(); q_fcs.delete(); q_done.delete();
                idle_inputs();
                @(posedge clk); #1;
                rstn = 1;
                return;
            end
            repeat ($urandom_range(1, 4)) @(negedge clk);
            if (spur && kk == 0) begin
                @(posedge clk); #1; bus.fc_done = 1;
                @(posedge clk); #1; bus.fc_done = 0;
                @(negedge clk);
                chk("spur_fc_no_fcstart", bus.fc_start, 0);
                chk("spur_fc_cnt", bus.conv_cnt, kk);
                chk("spur_fc_busy", bus.busy, 1);
            end
            @(posedge clk); #1; bus.conv_done = 1;
            @(posedge clk); #1; bus.conv_done = 0;
        end
        @(negedge clk);
        chk("loadfc_ready", bus.weightfc_tready, 1);
        chk("loadfc_cnt", bus.conv_cnt, NK);
        drive(2, mf, 0, 0);
        repeat ($urandom_range(1, 4)) @(negedge clk);
        @(posedge clk); #1; bus.fc_done = 1;
        @(posedge clk); #1; bus.fc_done = 0;
        @(negedge clk);
        chk("cnn_done_pulse", bus.cnn_done, 1);
        @(negedge clk);
        chk("cnn_done_cleared", bus.cnn_done, 0);
        chk("idle_busy", bus.busy, 0);
        chk("idle_cnt_hold", bus.conv_cnt, NK);
        t = 0;
    endtask

    // Monitor: every DUT-presented event is matched against the scoreboard queues
    always @(negedge clk) begin
        if (!rstn) begin
            pa_img <= 0; pa_w <= 0; pa_fc <= 0;
        end else begin
            if (bus.img_we || pa_img) chk("img_we_latency", bus.img_we, pa_img);
            if (bus.w_we || pa_w) chk("w_we_latency", bus.w_we, pa_w);
            if (bus.wfc_we || pa_fc) chk("wfc_we_latency", bus.wfc_we, pa_fc);
            if (bus.img_we) begin
                if (q_img.size() == 0) chk("img_we_unexpected", 1, 0);
                else chk("img_write", int'(bus.img_addr) * 256 + int'(bus.img_wdata), q_img.pop_front());
            end
            if (bus.w_we) begin
                if (q_w.size() == 0) chk("w_we_unexpected", 1, 0);
                else chk("w_write", int'(bus.w_addr) * 2 + int'(bus.w_wdata), q_w.pop_front());
            end
            if (bus.wfc_we) begin
                if (q_fc.size() == 0) chk("wfc_we_unexpected", 1, 0);
                else chk("wfc_write", int'(bus.wfc_addr) * 2 + int'(bus.wfc_wdata), q_fc.pop_front());
            end
            if (bus.start_window || bus.start_conv) begin
                chk("start_conv_with_window", bus.start_conv, bus.start_window);
                if (q_conv.size() == 0) chk("start_window_unexpected", 1, 0);
                else chk("start_window_cnt", bus.conv_cnt, q_conv.pop_front());
            end
            if (bus.fc_start) begin
                if (q_fcs.size() == 0) chk("fc_start_unexpected", 1, 0);
                else void'(q_fcs.pop_front());
            end
            if (bus.cnn_done) begin
                if (q_done.size() == 0) chk("cnn_done_unexpected", 1, 0);
                else void'(q_done.pop_front());
            end
            pa_img <= bus.image_tvalid & bus.image_tready;
            pa_w   <= bus.weight_tvalid & bus.weight_tready;
            pa_fc  <= bus.weightfc_tvalid & bus.weightfc_tready;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        #2 rstn = 0;
        #1 check_zero("reset_zero");
        repeat (2) @(posedge clk);
        #1 rstn = 1;
        run(0, 0, 0, 0, 0, 0, -1, 0);
        run(1, 2, 2, 2, 0, 0, -1, 0);
        run(2, 2, 2, 0, 0, 1, -1, 0);
        run(2, 0, 0, 0, 0, 0, -1, 1);
        @(negedge clk);
        chk("hold_restart_busy", bus.busy, 1);
        chk("hold_restart_cnt", bus.conv_cnt, 0);
        chk("hold_restart_ready", bus.image_tready, 1);
        @(posedge clk); #1;
        idle_inputs();
        rstn = 0;
        #1 check_zero("hold_reset_zero");
        @(posedge clk); #1 rstn = 1;
        run(2, 2, 2, 0, 0, 0, 1, 0);
        run(0, 0, 0, 0, 0, 0, -1, 0);
        run(0, 0, 0, 0, 4, 0, -1, 0);
        repeat (3) @(negedge clk);
        chk("q_img_empty", q_img.size(), 0);
        chk("q_w_empty", q_w.size(), 0);
        chk("q_fc_empty", q_fc.size(), 0);
        chk("q_conv_empty", q_conv.size(), 0);
        chk("q_fcs_empty", q_fcs.size(), 0);
        chk("q_done_empty", q_done.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bnn_seq_ctrl.md
Name: bnn_seq_ctrl

Overview:
Top-level sequencer for the BNN accelerator. After start_cnn it:
- streams the image, the conv weights and the FC weights into their on-chip buffers over valid/ready handshakes;
- launches the sliding-window/conv/add/relu/pooling pipeline once per kernel, then the FC stage;
- signals completion.
It owns image_tready, weight_tready, weightfc_tready, start_window, start_conv, conv_cnt and cnn_done for the datapath.

Parameters:
- IMG_PIXELS, 784, 8-bit pixels per image
- NUM_KERNEL, 6, conv kernels processed sequentially (≤15)
- KW_BITS, 25, binary weight bits per kernel
- FC_W_BITS, 8640, binary FC weight bits (864 inputs × 10 outputs)

Ports:
- clk  in  1  clock
- rstn  in  1  async active-low reset
- start_cnn  in  1  start request; sampled only in IDLE
- image_tvalid  in  1  pixel valid
- image_tdata  in  8  pixel
- image_tready  out  1  high while in LOAD_IMG
- weight_tvalid  in  1  conv weight bit valid
- weight_tdata  in  1  conv weight bit
- weight_tready  out  1  high while in LOAD_W
- weightfc_tvalid  in  1  FC weight bit valid
- weightfc_tdata  in  1  FC weight bit
- weightfc_tready  out  1  high while in LOAD_FC
- img_we / img_addr / img_wdata  out  1 / clog2(IMG_PIXELS) / 8  image buffer write port
- w_we / w_addr / w_wdata  out  1 / clog2(NUM_KERNEL*KW_BITS) / 1  conv weight buffer write port
- wfc_we / wfc_addr / wfc_wdata  out  1 / clog2(FC_W_BITS) / 1  FC weight buffer write port
- start_window  out  1  one-cycle pulse, launches sliding window
- start_conv  out  1  one-cycle pulse, coincident with start_window
- conv_done  in  1  pulse: current kernel finished through pooling
- fc_start  out  1  one-cycle pulse, launches FC
- fc_done  in  1  pulse: FC results written
- conv_cnt  out  4  kernel index in progress
- busy  out  1  high in every state except IDLE
- cnn_done  out  1  one-cycle completion pulse

Behaviour:
- Reset: state=IDLE; all counters 0; every output 0 (tready, we, addr, wdata, pulses, conv_cnt, busy, cnn_done). Asserting rstn low mid-operation aborts immediately. Partially loaded buffers are abandoned.
- All outputs are registered or decoded from the registered state; no combinational path from inputs to outputs.
- States: IDLE → LOAD_IMG → LOAD_W → CONV_START → CONV_WAIT → (CONV_START | LOAD_FC) → FC_START → FC_WAIT → DONE → IDLE.
- IDLE: start_cnn=1 → LOAD_IMG; conv_cnt and beat counter cleared. In any other state start_cnn is ignored.
- Load states:
  - A beat is accepted when tvalid & tready.
  - The beat counter increments per beat.
  - On the beat where counter = N-1 (N = IMG_PIXELS, NUM_KERNEL*KW_BITS, or FC_W_BITS), the FSM advances and the counter clears. tready therefore drops the cycle after the last beat, and no extra beat is accepted.
  - Buffer write occurs 1 cycle after each accepted beat: we=1, addr = beat index, wdata = captured tdata.
  - tvalid low stalls without penalty.
- CONV_START (1 cycle): start_window=start_conv=1 → CONV_WAIT.
- CONV_WAIT: waits indefinitely for conv_done.
  - conv_done with conv_cnt<NUM_KERNEL-1 → conv_cnt+1, CONV_START.
  - conv_done with conv_cnt=NUM_KERNEL-1 → conv_cnt=NUM_KERNEL, LOAD_FC.
  - conv_done in any other state is ignored.
- FC_START (1 cycle): fc_start=1 → FC_WAIT. FC_WAIT → DONE on fc_done; fc_done in other states is ignored.
- DONE (1 cycle): cnn_done=1, busy=0 next cycle → IDLE. conv_cnt holds NUM_KERNEL until the next accepted start.
- If start_cnn=1 in the DONE cycle, it is not accepted; it must be high in IDLE.
- Counters saturate only through FSM transitions; no wrap is possible.

Test Plan (IMG_PIXELS=4, NUM_KERNEL=2, KW_BITS=3, FC_W_BITS=5):
1. Nominal run: start, 4 pixels 0x11..0x44 back-to-back, 6 weight bits, 2 conv_done, 5 FC bits, fc_done.
   - img writes at addr 0..3 with data 0x11..0x44, each 1 cycle after its beat.
   - 2 start_window/start_conv pulses, with conv_cnt 0 then 1.
   - conv_cnt=2 in LOAD_FC.
   - cnn_done pulses exactly once, 1 cycle after fc_done.
2. Bubbly image valid (toggle every cycle):
   - exactly 4 writes; image_tready low the cycle after the 4th beat.
   - 5th asserted tvalid is not accepted, and img_we stays 0.
3. Spurious conv_done during LOAD_W and fc_done during CONV_WAIT:
   - no state change, conv_cnt unchanged, no fc_start.
4. start_cnn held high throughout a run:
   - no restart while busy.
   - new run begins only from IDLE, with conv_cnt cleared to 0.
5. rstn low during CONV_WAIT (conv_cnt=1):
   - all outputs 0 immediately, including busy and conv_cnt.
   - after release, a fresh start reloads from img_addr 0.
6. Last-beat boundary: weight_tvalid held high for 10 cycles in LOAD_W.
   - exactly 6 w_we pulses with addr 0..5.
   - weight_tready low from the 7th cycle; start_conv follows exactly 1 cycle after LOAD_W exit.
